// File: rtl/ring_buffer_serial_drain_if.sv
// Read-port bundle between a RingBuffer instance and its serial drain.
// master = drain (issues pops), slave = RingBuffer (answers them).
interface ring_buffer_serial_drain_if #(
   parameter int DATA_WIDTH = 8
);
   // Handshake: readEnable is a one-cycle registered pop request. In the cycle after
   // the edge that sampled it, dataReadAck=1 with dataRead valid means a byte was
   // popped; dataReadAck=0 means nothing was popped. Only one request is in flight.
   logic                  readEnable;
   logic                  dataReadAck;
   logic [DATA_WIDTH-1:0] dataRead;
   logic [31:0]           bufferLength;

   modport master (
      output readEnable,
      input  dataReadAck,
      input  dataRead,
      input  bufferLength
   );

   modport slave (
      input  readEnable,
      output dataReadAck,
      output dataRead,
      output bufferLength
   );
endinterface

// File: rtl/ring_buffer_serial_drain.sv
// Pops bytes from a RingBuffer and shifts each out as a start/data(LSB first)/stop frame.
// Optional even-parity bit between data and stop is enabled by defining RING_DRAIN_PARITY_EN.
module ring_buffer_serial_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              txEnable,
   ring_buffer_serial_drain_if.master        rb,
   output logic                              txLine,
   output logic                              busy,
   output logic [31:0]                       bytesSent,
   output logic [2:0]                        state_dbg
);

   localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [15:0]     CLK_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT_ACK = 3'd2,
      START    = 3'd3,
      DATA     = 3'd4,
`ifdef RING_DRAIN_PARITY_EN
      PARITY   = 3'd5,
`endif
      STOP     = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [15:0]           clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  read_en_q, read_en_d;
   logic                  tx_q, tx_d;
   logic [31:0]           sent_q, sent_d;
`ifdef RING_DRAIN_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic bit_done;
   logic can_start;

   assign bit_done  = (clk_cnt_q == CLK_LAST);
   assign can_start = txEnable && (rb.bufferLength != 32'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         read_en_q <= 1'b0;
         tx_q      <= 1'b1;
         sent_q    <= '0;
`ifdef RING_DRAIN_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         read_en_q <= read_en_d;
         tx_q      <= tx_d;
         sent_q    <= sent_d;
`ifdef RING_DRAIN_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      sent_d    = sent_q;
`ifdef RING_DRAIN_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (can_start) begin
               state_d = REQ;
            end
         end

         REQ: begin
            state_d = WAIT_ACK;
         end

         // No ack means the occupancy we acted on was stale; nothing was popped.
         WAIT_ACK: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (rb.dataReadAck) begin
               shift_d = rb.dataRead;
`ifdef RING_DRAIN_PARITY_EN
               parity_d = ^rb.dataRead;
`endif
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end

         START: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               state_d   = DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               shift_d   = shift_q >> 1;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
`ifdef RING_DRAIN_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

`ifdef RING_DRAIN_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               state_d   = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
`endif

         // Chaining straight into REQ gives the fixed two idle-high cycles between frames.
         STOP: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               sent_d    = sent_q + 32'd1;
               state_d   = can_start ? REQ : IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so txLine/readEnable have no input path.
   always_comb begin
      read_en_d = (state_d == REQ);
      tx_d      = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef RING_DRAIN_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign rb.readEnable = read_en_q;
   assign txLine        = tx_q;
   assign busy          = (state_q != IDLE);
   assign bytesSent     = sent_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_ring_buffer_serial_drain.sv
// Bench for ring_buffer_serial_drain: RingBuffer stand-in, frame-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ring_buffer_serial_drain;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef RING_DRAIN_PARITY_EN
   localparam int PAR = 1;
   localparam logic [15:0] EXP_A5 = 16'b0000_0101_0100_1010;
   localparam logic [15:0] EXP_07 = 16'b0000_0110_0000_1110;
`else
   localparam int PAR = 0;
   localparam logic [15:0] EXP_A5 = 16'b0000_0011_0100_1010;
   localparam logic [15:0] EXP_07 = 16'b0000_0010_0000_1110;
`endif
   localparam int NB    = DW + 2 + PAR;
   localparam int FRAME = NB * CPB;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_en = 1'b0;
   logic tx_line, busy;
   logic [31:0] bytes_sent;
   logic [2:0]  state_dbg;

   always #5 clk = ~clk;

   ring_buffer_serial_drain_if #(.DATA_WIDTH(DW)) rb ();

   ring_buffer_serial_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (rst),
      .txEnable  (tx_en),
      .rb        (rb),
      .txLine    (tx_line),
      .busy      (busy),
      .bytesSent (bytes_sent),
      .state_dbg (state_dbg)
   );

   // ---------------- RingBuffer stand-in ----------------
   logic [DW-1:0] ring_q[$];
   logic          ack = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [31:0]   rb_len = '0;
   logic          force_len_en = 1'b0;
   logic [31:0]   force_len = '0;
   logic          pending = 1'b0;

   assign rb.dataReadAck  = ack;
   assign rb.dataRead     = rdata;
   assign rb.bufferLength = rb_len;

   initial begin : ring_model
      forever begin
         @(posedge clk);
         #1;
         if (pending && ring_q.size() > 0) begin
            ack   = 1'b1;
            rdata = ring_q.pop_front();
         end else begin
            ack   = 1'b0;
            rdata = '0;
         end
         pending = 1'b0;
         #2;
         rb_len = force_len_en ? force_len : 32'(ring_q.size());
         @(negedge clk);
         pending = (rb.readEnable === 1'b1);
      end
   end

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle line values of the frame in flight: bit0 = line, bit1 = last cycle.
   logic [1:0] exp_q[$];
   int         m_phase = 0;   // 0 idle, 1 request, 2 awaiting ack, 3 frame on the line
   logic [31:0] m_bytes = '0;
   int         rd_pulses = 0;

   function automatic void push_frame(input logic [DW-1:0] b);
      logic [NB-1:0] bits;
      bits = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) bits[i+1] = b[i];
      if (PAR == 1) bits[DW+1] = ^b;
      bits[NB-1] = 1'b1;
      for (int i = 0; i < NB; i++) begin
         for (int c = 0; c < CPB; c++) begin
            exp_q.push_back({(i == NB - 1) && (c == CPB - 1), bits[i]});
         end
      end
   endfunction

   initial begin : compare
      logic [1:0] cur;
      logic       exp_tx;
      forever begin
         @(negedge clk);
         cur    = 2'b00;
         exp_tx = 1'b1;
         if (m_phase == 3 && exp_q.size() > 0) begin
            cur    = exp_q.pop_front();
            exp_tx = cur[0];
         end
         chk("readEnable", 32'(rb.readEnable), 32'(m_phase == 1));
         chk("busy",       32'(busy),          32'(m_phase != 0));
         chk("txLine",     32'(tx_line),       32'(exp_tx));
         chk("bytesSent",  bytes_sent,         m_bytes);
         if (rb.readEnable === 1'b1) rd_pulses++;
         if (rst) begin
            m_phase = 0;
            exp_q.delete();
            m_bytes = '0;
         end else begin
            case (m_phase)
               0: if (tx_en && rb_len != 0) m_phase = 1;
               1: m_phase = 2;
               2: begin
                  if (ack) begin
                     push_frame(rdata);
                     m_phase = 3;
                  end else begin
                     m_phase = 0;
                  end
               end
               default: begin
                  if (cur[1]) begin
                     m_bytes = m_bytes + 32'd1;
                     m_phase = (tx_en && rb_len != 0) ? 1 : 0;
                  end
               end
            endcase
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_start();
      int t = 0;
      while (tx_line !== 1'b0 && t < 200) begin
         step();
         t++;
      end
      chk("start_bit_seen", 32'(tx_line), 32'd0);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < 1000) begin
         step();
         t++;
      end
      chk("return_to_idle", 32'(busy), 32'd0);
   endtask

   task automatic capture_frame(output logic [15:0] bits);
      bits = '0;
      wait_start();
      step(CPB / 2);
      for (int i = 0; i < NB; i++) begin
         bits[i] = tx_line;
         if (i < NB - 1) step(CPB);
      end
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      logic [15:0] cap;
      int          n;

      // Reset held two cycles with a start condition present.
      rst = 1'b1; tx_en = 1'b1; force_len_en = 1'b1; force_len = 32'd5;
      step(2);
      chk("reset_readEnable", 32'(rb.readEnable), 32'd0);
      chk("reset_txLine",     32'(tx_line),       32'd1);
      chk("reset_busy",       32'(busy),          32'd0);
      chk("reset_bytesSent",  bytes_sent,         32'd0);
      rst = 1'b0; force_len_en = 1'b0; tx_en = 1'b0;
      step(3);

      // Single byte 0xA5.
      ring_q.push_back(8'hA5);
      tx_en = 1'b1;
      capture_frame(cap);
      chk("frame_a5", 32'(cap), 32'(EXP_A5));
      wait_idle();
      chk("a5_bytesSent", bytes_sent, 32'd1);
      chk("a5_pulses",    32'(rd_pulses), 32'd1);

      // Three queued bytes back to back: span covers three frames plus two 2-cycle gaps.
      ring_q.push_back(8'h01);
      ring_q.push_back(8'h02);
      ring_q.push_back(8'h03);
      wait_start();
      n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         step();
         n++;
      end
      chk("three_frame_span", 32'(n), 32'(3 * FRAME + 4));
      step(10);
      chk("three_bytesSent", bytes_sent, 32'd4);
      chk("three_pulses",    32'(rd_pulses), 32'd4);
      chk("three_len_empty", rb_len, 32'd0);

      // Stale occupancy: length claims one entry for one cycle but nothing is popped.
      force_len_en = 1'b1; force_len = 32'd1;
      step();
      force_len = 32'd0;
      step(10);
      chk("stale_bytesSent", bytes_sent, 32'd4);
      chk("stale_pulses",    32'(rd_pulses), 32'd5);
      chk("stale_txLine",    32'(tx_line), 32'd1);
      chk("stale_busy",      32'(busy), 32'd0);
      force_len_en = 1'b0;
      ring_q.push_back(8'h5A);
      wait_start();
      wait_idle();
      chk("retry_bytesSent", bytes_sent, 32'd5);
      chk("retry_pulses",    32'(rd_pulses), 32'd6);

      // txEnable dropped during data bit 3 of 0x3C with more data waiting.
      ring_q.push_back(8'h3C);
      ring_q.push_back(8'h11);
      ring_q.push_back(8'h22);
      ring_q.push_back(8'h33);
      ring_q.push_back(8'h44);
      wait_start();
      step(CPB + 3 * CPB + 1);
      tx_en = 1'b0;
      wait_idle();
      step(20);
      chk("drop_bytesSent", bytes_sent, 32'd6);
      chk("drop_pulses",    32'(rd_pulses), 32'd7);
      chk("drop_len",       rb_len, 32'd4);
      chk("drop_busy",      32'(busy), 32'd0);

      // Reset during data bit 5 aborts the frame; the following frame is whole.
      ring_q.delete();
      ring_q.push_back(8'h81);
      tx_en = 1'b1;
      wait_start();
      step(CPB + 5 * CPB + 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_txLine",    32'(tx_line), 32'd1);
      chk("abort_bytesSent", bytes_sent, 32'd0);
      chk("abort_busy",      32'(busy), 32'd0);
      chk("abort_state",     32'(state_dbg), 32'd0);
      step(3);
      ring_q.push_back(8'h07);
      capture_frame(cap);
      chk("frame_07", 32'(cap), 32'(EXP_07));
      wait_idle();
      chk("post_reset_bytesSent", bytes_sent, 32'd1);
      step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
